// File: rtl/secuenciador_tipo_r.sv
// Multi-cycle sequencer for the R-type datapath: fetches words from a synchronous ROM,
// latches them into the instruction register and drives ALU control and register write enable.
module secuenciador_tipo_r #(
    parameter int ADDR_W  = 5,
    parameter int LAST_PC = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr_data,
    input  logic              alu_zf,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [31:0]       ir,
    output logic [2:0]        alu_ctl,
    output logic              rb_we,
    output logic              zf_ult,
    output logic              ocupado,
    output logic              fin,
    output logic              err_ilegal,
    output logic [ADDR_W:0]   num_instr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EJECUTA,
        S_ESCRIBE,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(LAST_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [31:0]         ir_q;
    logic                zf_q;
    logic                err_q;
    logic [ADDR_W:0]     cnt_q;

    logic                op_wr, op_rd, op_halt;
    logic                funct_ok;
    logic [2:0]          alu_dec;
    logic                ilegal;
    logic                start_run;

    assign op_wr   = (ir_q[31:26] == 6'b000000);
    assign op_rd   = (ir_q[31:26] == 6'b000001);
    assign op_halt = (ir_q[31:26] == 6'b111111);

    always_comb begin
        funct_ok = 1'b1;
        alu_dec  = 3'b000;
        case (ir_q[5:0])
            6'b100000: alu_dec = 3'b010;
            6'b100010: alu_dec = 3'b110;
            6'b101010: alu_dec = 3'b111;
            6'b100100: alu_dec = 3'b000;
            6'b100101: alu_dec = 3'b001;
            default:   funct_ok = 1'b0;
        endcase
    end

    // Halt ignores funct; the two R-type opcodes need a known funct.
    assign ilegal    = !op_halt && !((op_wr || op_rd) && funct_ok);
    assign start_run = start && ((state_q == S_IDLE) || (state_q == S_FIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: if (start_run) state_d = S_FETCH;
            S_FETCH:       state_d = S_DECODE;
            S_DECODE:      state_d = S_EJECUTA;
            S_EJECUTA:     state_d = (ilegal || op_halt) ? S_FIN : S_ESCRIBE;
            S_ESCRIBE:     state_d = (pc_q == PC_LAST) ? S_FIN : S_FETCH;
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            zf_q  <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    if (start_run) begin
                        pc_q  <= '0;
                        cnt_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_DECODE: ir_q <= instr_data;
                S_EJECUTA: begin
                    zf_q <= alu_zf;
                    if (ilegal) err_q <= 1'b1;
                end
                S_ESCRIBE: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (pc_q != PC_LAST) pc_q <= pc_q + PC_ONE;
                end
                default: ;
            endcase
        end
    end

    // Write strobe is purely state-derived, so a reset drops it on the next cycle.
    always_comb begin
        ocupado = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                  (state_q == S_EJECUTA) || (state_q == S_ESCRIBE);
        fin     = (state_q == S_FIN);
        alu_ctl = ((state_q == S_EJECUTA) || (state_q == S_ESCRIBE)) ? alu_dec : 3'b000;
        rb_we   = (state_q == S_ESCRIBE) && op_wr && (ir_q[15:11] != 5'd0);
    end

    assign pc_addr    = pc_q;
    assign ir         = ir_q;
    assign zf_ult     = zf_q;
    assign err_ilegal = err_q;
    assign num_instr  = cnt_q;

endmodule

// File: tb/tb_secuenciador_tipo_r.sv
// Directed bench for secuenciador_tipo_r: two instances (LAST_PC=31 and LAST_PC=1) share one ROM image.
module tb_secuenciador_tipo_r;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, zf;
    logic [31:0] rom [32];
    logic [31:0] rd_a, rd_b;

    logic [4:0]  pc_a, pc_b;
    logic [31:0] ir_a, ir_b;
    logic [2:0]  alu_a, alu_b;
    logic        we_a, we_b, zfu_a, zfu_b, ocu_a, ocu_b, fin_a, fin_b, err_a, err_b;
    logic [5:0]  num_a, num_b;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] W_ADD   = 32'h01311020;
    localparam logic [31:0] W_ADDRD = 32'h05311020;
    localparam logic [31:0] W_HALT  = 32'hFC000000;

    secuenciador_tipo_r #(.ADDR_W(5), .LAST_PC(31)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .instr_data(rd_a), .alu_zf(zf),
        .pc_addr(pc_a), .ir(ir_a), .alu_ctl(alu_a), .rb_we(we_a), .zf_ult(zfu_a),
        .ocupado(ocu_a), .fin(fin_a), .err_ilegal(err_a), .num_instr(num_a)
    );

    secuenciador_tipo_r #(.ADDR_W(5), .LAST_PC(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .instr_data(rd_b), .alu_zf(zf),
        .pc_addr(pc_b), .ir(ir_b), .alu_ctl(alu_b), .rb_we(we_b), .zf_ult(zfu_b),
        .ocupado(ocu_b), .fin(fin_b), .err_ilegal(err_b), .num_instr(num_b)
    );

    always @(posedge clk) begin
        rd_a <= rom[pc_a];
        rd_b <= rom[pc_b];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    endtask

    task automatic test_reset;
        logic [50:0] got;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; zf = 1'b0;
        clear_rom();
        step(); step();
        got = {pc_a, ir_a, alu_a, we_a, zfu_a, ocu_a, fin_a, err_a, num_a};
        total++;
        if (got !== 51'd0) begin
            bad++; $display("FAIL reset_a got %h want 0", got);
        end
        got = {pc_b, ir_b, alu_b, we_b, zfu_b, ocu_b, fin_b, err_b, num_b};
        total++;
        if (got !== 51'd0) begin
            bad++; $display("FAIL reset_b got %h want 0", got);
        end
        rst = 1'b0;
        step();
    endtask

    // Layout of per-cycle vectors: {rb_we, alu_ctl, fin, ocupado}
    task automatic test_add_read;
        logic [5:0] got, exp;
        clear_rom();
        rom[0] = W_ADD; rom[1] = W_ADDRD; rom[2] = W_HALT;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            zf = (c == 11);
            exp = {(c == 4), ((c == 3) || (c == 4) || (c == 7) || (c == 8)) ? 3'b010 : 3'b000,
                   (c == 12), (c < 12)};
            got = {we_a, alu_a, fin_a, ocu_a};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL add_read_cycle c=%0d got %b want %b", c, got, exp);
            end
            if (c < 12) step();
        end
        zf = 1'b0;
        total++;
        if (num_a !== 6'd2) begin bad++; $display("FAIL add_read_num got %0d want 2", num_a); end
        total++;
        if (ir_a !== W_HALT) begin bad++; $display("FAIL add_read_ir got %h want %h", ir_a, W_HALT); end
        total++;
        if (zfu_a !== 1'b1) begin bad++; $display("FAIL add_read_zf got %b want 1", zfu_a); end
        total++;
        if ({pc_a, err_a} !== {5'd2, 1'b0}) begin
            bad++; $display("FAIL add_read_pc_err got %h want %h", {pc_a, err_a}, {5'd2, 1'b0});
        end
    endtask

    // start held high through the run must be ignored while busy
    task automatic test_sub_slt;
        logic [5:0] got, exp;
        clear_rom();
        rom[0] = 32'h00E21822; rom[1] = 32'h0145202A;
        start_b = 1'b1; step();
        for (int c = 1; c <= 10; c++) begin
            if (c == 9) start_b = 1'b0;
            exp = {((c == 4) || (c == 8)),
                   ((c == 3) || (c == 4)) ? 3'b110 : ((c == 7) || (c == 8)) ? 3'b111 : 3'b000,
                   (c >= 9), (c < 9)};
            got = {we_b, alu_b, fin_b, ocu_b};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL sub_slt_cycle c=%0d got %b want %b", c, got, exp);
            end
            if (c < 10) step();
        end
        total++;
        if (num_b !== 6'd2) begin bad++; $display("FAIL sub_slt_num got %0d want 2", num_b); end
        total++;
        if (pc_b !== 5'd1) begin bad++; $display("FAIL sub_slt_pc got %0d want 1", pc_b); end
    endtask

    task automatic test_and_or;
        logic [5:0] got, exp;
        clear_rom();
        rom[0] = 32'h00E21824; rom[1] = 32'h00E21825;
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp = {((c == 4) || (c == 8)),
                   ((c == 7) || (c == 8)) ? 3'b001 : 3'b000,
                   (c == 9), (c < 9)};
            got = {we_b, alu_b, fin_b, ocu_b};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL and_or_cycle c=%0d got %b want %b", c, got, exp);
            end
            if (c < 9) step();
        end
    endtask

    task automatic test_illegal;
        logic [3:0] got, exp;
        clear_rom();
        rom[0] = 32'h08000020;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp = {1'b0, (c == 4), (c == 4), (c < 4)};
            got = {we_a, fin_a, err_a, ocu_a};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL illegal_cycle c=%0d got %b want %b", c, got, exp);
            end
            if (c < 4) step();
        end
        total++;
        if (num_a !== 6'd0) begin bad++; $display("FAIL illegal_num got %0d want 0", num_a); end
        step();
        total++;
        if (err_a !== 1'b1) begin bad++; $display("FAIL illegal_sticky got %b want 1", err_a); end
        rom[0] = W_HALT;
        start_a = 1'b1; step(); start_a = 1'b0;
        got = {ocu_a, fin_a, err_a, 1'b0};
        total++;
        if (got !== 4'b1000) begin bad++; $display("FAIL illegal_restart got %b want 1000", got); end
        step(); step(); step();
        got = {ocu_a, fin_a, err_a, 1'b0};
        total++;
        if (got !== 4'b0100) begin bad++; $display("FAIL illegal_rerun_end got %b want 0100", got); end
    endtask

    task automatic test_rd_zero;
        logic [5:0] got, exp;
        clear_rom();
        rom[0] = 32'h01310020; rom[1] = W_HALT;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp = {1'b0, ((c == 3) || (c == 4)) ? 3'b010 : 3'b000, (c == 8), (c < 8)};
            got = {we_a, alu_a, fin_a, ocu_a};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rd_zero_cycle c=%0d got %b want %b", c, got, exp);
            end
            if (c < 8) step();
        end
        total++;
        if (num_a !== 6'd1) begin bad++; $display("FAIL rd_zero_num got %0d want 1", num_a); end
    endtask

    task automatic test_reset_mid;
        logic [50:0] got;
        clear_rom();
        rom[0] = W_ADD; rom[1] = W_ADD; rom[2] = W_HALT;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int c = 1; c < 8; c++) step();
        total++;
        if ({we_a, num_a, pc_a} !== {1'b1, 6'd1, 5'd1}) begin
            bad++; $display("FAIL reset_mid_pre got %h want %h", {we_a, num_a, pc_a}, {1'b1, 6'd1, 5'd1});
        end
        rst = 1'b1; start_a = 1'b1; step(); rst = 1'b0;
        got = {pc_a, ir_a, alu_a, we_a, zfu_a, ocu_a, fin_a, err_a, num_a};
        total++;
        if (got !== 51'd0) begin bad++; $display("FAIL reset_mid_clear got %h want 0", got); end
        step();
        total++;
        if ({ocu_a, pc_a} !== {1'b1, 5'd0}) begin
            bad++; $display("FAIL reset_mid_restart got %h want %h", {ocu_a, pc_a}, {1'b1, 5'd0});
        end
        step(); step();
        total++;
        if (alu_a !== 3'b010) begin bad++; $display("FAIL reset_mid_ej got %b want 010", alu_a); end
        step();
        total++;
        if (we_a !== 1'b1) begin bad++; $display("FAIL reset_mid_we got %b want 1", we_a); end
        step();
        total++;
        if ({ocu_a, pc_a, num_a} !== {1'b1, 5'd1, 6'd1}) begin
            bad++; $display("FAIL reset_mid_held_start got %h want %h", {ocu_a, pc_a, num_a}, {1'b1, 5'd1, 6'd1});
        end
        start_a = 1'b0;
    endtask

    task automatic test_full_run;
        logic [7:0] got, exp;
        logic [4:0] epc;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = W_ADDRD;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int c = 1; c <= 129; c++) begin
            epc = (c == 129) ? 5'd31 : 5'((c - 1) / 4);
            exp = {epc, 1'b0, (c == 129), (c < 129)};
            got = {pc_a, we_a, fin_a, ocu_a};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL full_run_cycle c=%0d got %b want %b", c, got, exp);
            end
            if (c < 129) step();
        end
        total++;
        if (num_a !== 6'd32) begin bad++; $display("FAIL full_run_num got %0d want 32", num_a); end
        step();
        total++;
        if ({pc_a, fin_a, num_a} !== {5'd31, 1'b1, 6'd32}) begin
            bad++; $display("FAIL full_run_hold got %h want %h", {pc_a, fin_a, num_a}, {5'd31, 1'b1, 6'd32});
        end
    endtask

    initial begin
        test_reset();
        test_add_read();
        test_sub_slt();
        test_and_or();
        test_illegal();
        test_rd_zero();
        test_reset_mid();
        test_full_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
